// File: rtl/rgb_channel_joiner.sv
// rtl/rgb_channel_joiner.sv - joins three buffered 8-bit channels into a positioned 24-bit pixel stream; optional RGB_JOINER_GRAY_EN adds o_pix_gray

// Per-channel FIFO: registered busy (full), push on vld&~busy, pop on request.
module rgb_joiner_chan_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  input  logic             i_pop,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_nxt;

  // busy already blocks pushes into a full FIFO; pop is only honoured when data exists
  assign w_push = i_vld & ~r_busy;
  assign w_pop  = i_pop & (r_cnt != '0);

  // Occupancy after this edge; simultaneous push and pop cancel out
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Pointers, count and busy; busy sits high through reset and drops on the first edge after
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt == C_FULL);
    end
  end

  // Storage needs no reset: entries are only visible through the reset pointers
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_busy = r_busy;
  assign o_vld  = (r_cnt != '0);
  assign o_data = r_mem[r_rd_ptr];

endmodule

// Joiner top: three channel FIFOs feeding one output register with position tracking.
module rgb_channel_joiner #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     i_newR_busy,
  input  logic                     i_newR_vld,
  input  logic [7:0]               i_newR_data,
  output logic                     i_newG_busy,
  input  logic                     i_newG_vld,
  input  logic [7:0]               i_newG_data,
  output logic                     i_newB_busy,
  input  logic                     i_newB_vld,
  input  logic [7:0]               i_newB_data,
  input  logic                     o_pix_busy,
  output logic                     o_pix_vld,
  output logic [23:0]              o_pix_data,
  output logic [$clog2(IMG_W)-1:0] o_pix_x,
  output logic [$clog2(IMG_H)-1:0] o_pix_y,
  output logic                     o_pix_last,
  output logic [15:0]              o_frame_cnt
`ifdef RGB_JOINER_GRAY_EN
  ,
  output logic [7:0]               o_pix_gray
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic          w_r_vld;
  logic          w_g_vld;
  logic          w_b_vld;
  logic [7:0]    w_r_data;
  logic [7:0]    w_g_data;
  logic [7:0]    w_b_data;
  logic          w_all_vld;
  logic          w_out_hs;
  logic          w_load;

  logic          r_pix_vld;
  logic [23:0]   r_pix_data;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_last;
  logic [15:0]   r_frame_cnt;

  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_frame_done;

  rgb_joiner_chan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_r (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_newR_vld),
    .i_data (i_newR_data),
    .o_busy (i_newR_busy),
    .i_pop  (w_load),
    .o_vld  (w_r_vld),
    .o_data (w_r_data)
  );

  rgb_joiner_chan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_g (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_newG_vld),
    .i_data (i_newG_data),
    .o_busy (i_newG_busy),
    .i_pop  (w_load),
    .o_vld  (w_g_vld),
    .o_data (w_g_data)
  );

  rgb_joiner_chan_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo_b (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_newB_vld),
    .i_data (i_newB_data),
    .o_busy (i_newB_busy),
    .i_pop  (w_load),
    .o_vld  (w_b_vld),
    .o_data (w_b_data)
  );

  // A pixel exists only when every channel has its component; the output
  // register accepts it when empty or emptying this edge (full throughput)
  assign w_all_vld = w_r_vld & w_g_vld & w_b_vld;
  assign w_out_hs  = r_pix_vld & ~o_pix_busy;
  assign w_load    = w_all_vld & (~r_pix_vld | w_out_hs);

  // Output register: load packed pixel, or drop valid once it has been taken
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pix_vld  <= 1'b0;
      r_pix_data <= '0;
    end else if (w_load) begin
      r_pix_vld  <= 1'b1;
      r_pix_data <= {w_b_data, w_g_data, w_r_data};
    end else if (w_out_hs) begin
      r_pix_vld  <= 1'b0;
    end
  end

  // Next raster position; advances only when the presented pixel is consumed
  always_comb begin
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_frame_done = 1'b0;
    if (w_out_hs) begin
      if (r_x == X_MAX) begin
        w_x_nxt = '0;
        if (r_y == Y_MAX) begin
          w_y_nxt      = '0;
          w_frame_done = 1'b1;
        end else begin
          w_y_nxt = r_y + 1'b1;
        end
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  // Position, last-pixel flag and frame counter registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_last      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_last <= (w_x_nxt == X_MAX) && (w_y_nxt == Y_MAX);
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef RGB_JOINER_GRAY_EN
  logic [15:0] w_gray_sum;
  logic [7:0]  r_gray;

  // Luma weights sum to 256, so the upper byte is the gray value; the
  // maximum 256*255 fits in 16 bits
  assign w_gray_sum = (16'd77  * {8'd0, w_r_data})
                    + (16'd150 * {8'd0, w_g_data})
                    + (16'd29  * {8'd0, w_b_data});

  // Gray loads alongside the pixel so it needs no extra pipeline stage
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_gray <= '0;
    end else if (w_load) begin
      r_gray <= w_gray_sum[15:8];
    end
  end

  assign o_pix_gray = r_gray;
`endif

  assign o_pix_vld   = r_pix_vld;
  assign o_pix_data  = r_pix_data;
  assign o_pix_x     = r_x;
  assign o_pix_y     = r_y;
  assign o_pix_last  = r_last;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rgb_channel_joiner.sv
// tb/tb_rgb_channel_joiner.sv - directed self-checking bench for rgb_channel_joiner (4x2 image, depth-2 FIFOs)
module tb_rgb_channel_joiner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_busy, g_busy, b_busy;
  logic        r_vld = 1'b0, g_vld = 1'b0, b_vld = 1'b0;
  logic [7:0]  r_data = '0, g_data = '0, b_data = '0;
  logic        sink_busy = 1'b0;
  logic        pix_vld;
  logic [23:0] pix_data;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;
  logic        pix_last;
  logic [15:0] frame_cnt;
`ifdef RGB_JOINER_GRAY_EN
  logic [7:0]  pix_gray;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_r[$];
  logic [7:0] q_g[$];
  logic [7:0] q_b[$];
  logic hs_r = 1'b0, hs_g = 1'b0, hs_b = 1'b0;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  x;
    logic [0:0]  y;
    logic        last;
    logic [15:0] fc;
    logic [7:0]  gray;
    longint      t;
  } pix_t;
  pix_t rx[$];

  always #5 clk = ~clk;

  rgb_channel_joiner #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_newR_busy (r_busy),
    .i_newR_vld  (r_vld),
    .i_newR_data (r_data),
    .i_newG_busy (g_busy),
    .i_newG_vld  (g_vld),
    .i_newG_data (g_data),
    .i_newB_busy (b_busy),
    .i_newB_vld  (b_vld),
    .i_newB_data (b_data),
    .o_pix_busy  (sink_busy),
    .o_pix_vld   (pix_vld),
    .o_pix_data  (pix_data),
    .o_pix_x     (pix_x),
    .o_pix_y     (pix_y),
    .o_pix_last  (pix_last),
    .o_frame_cnt (frame_cnt)
`ifdef RGB_JOINER_GRAY_EN
    ,
    .o_pix_gray  (pix_gray)
`endif
  );

  // Channel senders: retire the accepted head, then present the next queued value
  always @(posedge clk) begin
    #1;
    if (hs_r && q_r.size() > 0) void'(q_r.pop_front());
    if (hs_g && q_g.size() > 0) void'(q_g.pop_front());
    if (hs_b && q_b.size() > 0) void'(q_b.pop_front());
    if (q_r.size() > 0) begin r_vld = 1'b1; r_data = q_r[0]; end else r_vld = 1'b0;
    if (q_g.size() > 0) begin g_vld = 1'b1; g_data = q_g[0]; end else g_vld = 1'b0;
    if (q_b.size() > 0) begin b_vld = 1'b1; b_data = q_b[0]; end else b_vld = 1'b0;
  end

  // Monitor: inputs stay stable from here to the next rising edge, so this predicts the handshakes
  always @(negedge clk) begin
    pix_t p;
    hs_r = r_vld && !r_busy;
    hs_g = g_vld && !g_busy;
    hs_b = b_vld && !b_busy;
    if (rst_n && pix_vld && !sink_busy) begin
      p.data = pix_data; p.x = pix_x; p.y = pix_y; p.last = pix_last;
      p.fc = frame_cnt; p.t = longint'($time); p.gray = 8'h00;
`ifdef RGB_JOINER_GRAY_EN
      p.gray = pix_gray;
`endif
      rx.push_back(p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    q_r.push_back(r);
    q_g.push_back(g);
    q_b.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_r.delete(); q_g.delete(); q_b.delete();
    sink_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rx.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (pix_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0b expected 0", pix_vld); end
    n_cmp++; if (pix_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %06h expected 000000", pix_data); end
    n_cmp++; if ({pix_x, pix_y, pix_last} !== 4'b0) begin n_err++; $display("FAIL reset_pos: got x=%0d y=%0d last=%0b expected 0/0/0", pix_x, pix_y, pix_last); end
    n_cmp++; if (frame_cnt !== 16'h0) begin n_err++; $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
    n_cmp++; if ({r_busy, g_busy, b_busy} !== 3'b111) begin n_err++; $display("FAIL reset_busy: got %03b expected 111", {r_busy, g_busy, b_busy}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({r_busy, g_busy, b_busy} !== 3'b111) begin n_err++; $display("FAIL release_busy_held: got %03b expected 111", {r_busy, g_busy, b_busy}); end
    tick();
    n_cmp++; if ({r_busy, g_busy, b_busy} !== 3'b000) begin n_err++; $display("FAIL release_busy_drop: got %03b expected 000", {r_busy, g_busy, b_busy}); end
  endtask

  task automatic test_single();
    do_reset();
    push_pix(8'h11, 8'h22, 8'h33);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pix_vld !== 1'b0) begin n_err++; $display("FAIL single_early_vld: got %0b expected 0", pix_vld); end
    @(negedge clk);
    n_cmp++; if (pix_vld !== 1'b1) begin n_err++; $display("FAIL single_vld: got %0b expected 1", pix_vld); end
    n_cmp++; if (pix_data !== 24'h332211) begin n_err++; $display("FAIL single_data: got %06h expected 332211", pix_data); end
    n_cmp++; if ({pix_x, pix_y, pix_last} !== 4'b0) begin n_err++; $display("FAIL single_pos: got x=%0d y=%0d last=%0b expected 0/0/0", pix_x, pix_y, pix_last); end
    tick();
    tick();
    n_cmp++; if (rx.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", rx.size()); end
  endtask

  task automatic test_skew();
    logic busy_seen = 1'b0;
    do_reset();
    q_r.push_back(8'hA1);
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (c == 2) q_g.push_back(8'hB2);
      if (c == 5) q_b.push_back(8'hC3);
      @(negedge clk);
      if (r_busy || g_busy) busy_seen = 1'b1;
      if (c == 7) begin
        n_cmp++; if (pix_vld !== 1'b0) begin n_err++; $display("FAIL skew_early_vld: got %0b expected 0 at cycle 7", pix_vld); end
      end
      if (c == 8) begin
        n_cmp++; if (pix_vld !== 1'b1) begin n_err++; $display("FAIL skew_vld: got %0b expected 1 at cycle 8", pix_vld); end
        n_cmp++; if (pix_data !== 24'hC3B2A1) begin n_err++; $display("FAIL skew_data: got %06h expected c3b2a1", pix_data); end
      end
    end
    n_cmp++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL skew_busy: got busy=1 on R/G expected 0 throughout"); end
    tick();
    n_cmp++; if (rx.size() !== 1) begin n_err++; $display("FAIL skew_count: got %0d expected 1", rx.size()); end
  endtask

  task automatic test_back_to_back();
    logic unstable = 1'b0;
    do_reset();
    sink_busy = 1'b1;
    for (int k = 0; k < 6; k++) push_pix(8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k));
    repeat (8) tick();
    @(negedge clk);
    n_cmp++; if (pix_vld !== 1'b1) begin n_err++; $display("FAIL bp_vld: got %0b expected 1", pix_vld); end
    n_cmp++; if (pix_data !== 24'h302010) begin n_err++; $display("FAIL bp_hold_data: got %06h expected 302010", pix_data); end
    n_cmp++; if ({r_busy, g_busy, b_busy} !== 3'b111) begin n_err++; $display("FAIL bp_busy: got %03b expected 111", {r_busy, g_busy, b_busy}); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pix_vld !== 1'b1 || pix_data !== 24'h302010) unstable = 1'b1;
    end
    n_cmp++; if (unstable !== 1'b0) begin n_err++; $display("FAIL bp_stable: got changing output expected 302010 held"); end
    tick();
    sink_busy = 1'b0;
    repeat (12) tick();
    n_cmp++; if (rx.size() !== 6) begin n_err++; $display("FAIL bp_count: got %0d expected 6", rx.size()); end
    for (int i = 0; i < 6 && i < rx.size(); i++) begin
      logic [23:0] ed;
      logic [1:0]  ex;
      logic [0:0]  ey;
      ed = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
      ex = 2'(i % 4);
      ey = 1'(i / 4);
      n_cmp++;
      if (rx[i].data !== ed || rx[i].x !== ex || rx[i].y !== ey) begin
        n_err++;
        $display("FAIL bp_pix%0d: got %06h (%0d,%0d) expected %06h (%0d,%0d)", i, rx[i].data, rx[i].x, rx[i].y, ed, ex, ey);
      end
    end
  endtask

  task automatic test_frame();
    logic gap = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) push_pix(8'(k), 8'(8'h40 + k), 8'(8'h80 + k));
    repeat (16) tick();
    n_cmp++; if (rx.size() !== 9) begin n_err++; $display("FAIL frame_count: got %0d expected 9", rx.size()); end
    for (int i = 0; i < 9 && i < rx.size(); i++) begin
      logic [23:0] ed;
      logic [1:0]  ex;
      logic [0:0]  ey;
      logic        el;
      logic [15:0] ef;
      ed = {8'(8'h80 + i), 8'(8'h40 + i), 8'(i)};
      ex = 2'(i % 4);
      ey = 1'((i / 4) % 2);
      el = (i == 7);
      ef = (i == 8) ? 16'd1 : 16'd0;
      n_cmp++;
      if (rx[i].data !== ed || rx[i].x !== ex || rx[i].y !== ey || rx[i].last !== el || rx[i].fc !== ef) begin
        n_err++;
        $display("FAIL frame_pix%0d: got %06h (%0d,%0d) last=%0b fc=%0d expected %06h (%0d,%0d) last=%0b fc=%0d",
                 i, rx[i].data, rx[i].x, rx[i].y, rx[i].last, rx[i].fc, ed, ex, ey, el, ef);
      end
      if (i > 0 && rx[i].t - rx[i-1].t != 10) gap = 1'b1;
    end
    n_cmp++; if (gap !== 1'b0) begin n_err++; $display("FAIL frame_rate: got a gap between pixels expected 1 pixel/cycle"); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL frame_cnt_end: got %0d expected 1", frame_cnt); end
    n_cmp++; if ({pix_vld, pix_x, pix_y} !== 4'b0010) begin n_err++; $display("FAIL frame_idle: got vld=%0b x=%0d y=%0d expected 0/1/0", pix_vld, pix_x, pix_y); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sink_busy = 1'b1;
    for (int k = 0; k < 3; k++) push_pix(8'(8'hE0 + k), 8'(8'hE4 + k), 8'(8'hE8 + k));
    q_r.push_back(8'hEF);
    repeat (6) tick();
    n_cmp++; if (pix_vld !== 1'b1) begin n_err++; $display("FAIL mid_pre_vld: got %0b expected 1", pix_vld); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pix_vld !== 1'b0 || pix_data !== 24'h0) begin n_err++; $display("FAIL mid_async_out: got vld=%0b data=%06h expected 0/000000", pix_vld, pix_data); end
    n_cmp++; if ({r_busy, g_busy, b_busy} !== 3'b111) begin n_err++; $display("FAIL mid_async_busy: got %03b expected 111", {r_busy, g_busy, b_busy}); end
    q_r.delete(); q_g.delete(); q_b.delete();
    rx.delete();
    tick();
    tick();
    rst_n = 1'b1;
    sink_busy = 1'b0;
    push_pix(8'h44, 8'h55, 8'h66);
    repeat (8) tick();
    n_cmp++; if (rx.size() !== 1) begin n_err++; $display("FAIL mid_count: got %0d expected 1", rx.size()); end
    if (rx.size() > 0) begin
      n_cmp++;
      if (rx[0].data !== 24'h665544 || rx[0].x !== 2'd0 || rx[0].y !== 1'd0 || rx[0].fc !== 16'd0) begin
        n_err++;
        $display("FAIL mid_first_pix: got %06h (%0d,%0d) fc=%0d expected 665544 (0,0) fc=0", rx[0].data, rx[0].x, rx[0].y, rx[0].fc);
      end
    end
  endtask

`ifdef RGB_JOINER_GRAY_EN
  task automatic test_gray();
    do_reset();
    n_cmp++; if (pix_gray !== 8'h00) begin n_err++; $display("FAIL gray_reset: got %02h expected 00", pix_gray); end
    push_pix(8'hFF, 8'hFF, 8'hFF);
    push_pix(8'hFF, 8'h00, 8'h00);
    repeat (8) tick();
    n_cmp++; if (rx.size() !== 2) begin n_err++; $display("FAIL gray_count: got %0d expected 2", rx.size()); end
    if (rx.size() == 2) begin
      n_cmp++; if (rx[0].gray !== 8'hFF) begin n_err++; $display("FAIL gray_white: got %02h expected ff", rx[0].gray); end
      n_cmp++; if (rx[1].gray !== 8'h4C) begin n_err++; $display("FAIL gray_red: got %02h expected 4c", rx[1].gray); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected completion within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_skew();
    test_back_to_back();
    test_frame();
    test_reset_mid();
`ifdef RGB_JOINER_GRAY_EN
    test_gray();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
